// File: rtl/seg_scan.sv
// Six-digit multiplexed 7-segment scanner: one digit slot per CNT_NUM+1 clocks,
// leading blank window per slot, frame latched once per full scan.
module seg_scan #(
  parameter int CNT_NUM   = 49_999,
  parameter int BLANK_NUM = 1_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] data_in,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  localparam int             NUM_DIG   = 6;
  localparam int             CW        = (CNT_NUM > 0) ? $clog2(CNT_NUM + 1) : 1;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(CNT_NUM);
  localparam logic [CW-1:0]  BLANK_END = CW'(BLANK_NUM);

  logic [CW-1:0]              cnt;
  logic [2:0]                 idx;
  logic [23:0]                frame;
  logic [NUM_DIG-1:0][7:0]    dec;
  logic                       blank;
  logic                       slot_end;
  logic                       frame_load;

  function automatic logic [7:0] dec_char(input logic [3:0] c);
    logic [7:0] p;
    p = 8'hFF;
    case (c)
      4'h0:        p = 8'h89;
      4'h1:        p = 8'h86;
      4'h2, 4'h3:  p = 8'hC7;
      4'h4:        p = 8'hC0;
      default:     p = 8'hFF;
    endcase
    return p;
  endfunction

  // Per-digit decoders fed only from the latched frame, never from data_in.
  for (genvar k = 0; k < NUM_DIG; k++) begin : g_dec
    assign dec[k] = dec_char(frame[23-4*k -: 4]);
  end

  // Zero-width blank window is resolved at elaboration so no constant compare exists.
  if (BLANK_NUM == 0) begin : g_noblank
    assign blank = 1'b0;
  end else begin : g_blank
    assign blank = (cnt < BLANK_END);
  end

  assign slot_end   = (cnt == CNT_LAST);
  assign frame_load = (cnt == '0) && (idx == 3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= 3'd0;
      frame <= 24'hFFFFFF;
      sel   <= 6'h3F;
      seg   <= 8'hFF;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end)
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      if (frame_load)
        frame <= data_in;
      if (blank) begin
        sel <= 6'h3F;
        seg <= 8'hFF;
      end else begin
        sel <= ~(6'b1 << idx);
        seg <= dec[idx];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: expected per-cycle sel/seg queued at stimulus time,
// popped each cycle; a second instance with no blanking checks continuous scan.
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] data_in = 24'h012345;
  logic [5:0]  sel, sel0;
  logic [7:0]  seg, seg0;

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;
  bit run    = 1'b0;

  typedef struct packed {
    logic [5:0] sel;
    logic [7:0] seg;
  } exp_t;
  exp_t sb[$];

  seg_scan #(.CNT_NUM(9), .BLANK_NUM(2)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .sel(sel), .seg(seg)
  );

  seg_scan #(.CNT_NUM(9), .BLANK_NUM(0)) dut0 (
    .clk(clk), .rst(rst), .data_in(data_in), .sel(sel0), .seg(seg0)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_char(input logic [3:0] c);
    logic [7:0] t [16];
    t = '{8'h89, 8'h86, 8'hC7, 8'hC7, 8'hC0, 8'hFF, 8'hFF, 8'hFF,
          8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    return t[c];
  endfunction

  function automatic logic [5:0] onehot_low(input int d);
    logic [5:0] s;
    s = 6'h3F;
    s[d] = 1'b0;
    return s;
  endfunction

  // Queue the first n cycles of a frame showing d: 2 blank + 8 lit per 10-cycle slot.
  task automatic push_frame(input logic [23:0] d, input int n);
    exp_t e;
    logic [3:0] nib;
    for (int i = 0; i < n; i++) begin
      if ((i % 10) < 2) begin
        e.sel = 6'h3F;
        e.seg = 8'hFF;
      end else begin
        nib   = d[23 - 4*(i/10) -: 4];
        e.sel = onehot_low(i / 10);
        e.seg = ref_char(nib);
      end
      sb.push_back(e);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (!rst && run) begin
      exp_t e;
      ecnt++;
      chk("b_sel", {26'd0, sel0}, {26'd0, onehot_low(((ecnt - 1) / 10) % 6)});
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("a_sel", {26'd0, sel}, {26'd0, e.sel});
        chk("a_seg", {24'd0, seg}, {24'd0, e.seg});
      end
    end
  end

  initial begin
    cyc(3);
    chk("rst_sel",  {26'd0, sel},  32'h3F);
    chk("rst_seg",  {24'd0, seg},  32'hFF);
    chk("rst_sel0", {26'd0, sel0}, 32'h3F);
    chk("rst_seg0", {24'd0, seg0}, 32'hFF);

    // Frames 1-4 after release; data changes never show before the next frame load.
    push_frame(24'h012345, 60);
    push_frame(24'h123450, 60);
    push_frame(24'h6789AF, 60);
    push_frame(24'h012345, 45);
    ecnt = 0;
    rst  = 1'b0;
    run  = 1'b1;
    cyc(35);
    data_in = 24'h123450;
    cyc(55);
    data_in = 24'h6789AF;
    cyc(60);
    data_in = 24'h012345;
    cyc(75);

    // Mid-slot reset at cnt=5, idx=4 blanks immediately.
    chk("pre_rst_q", sb.size(), 0);
    run = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_sel",  {26'd0, sel},  32'h3F);
    chk("mid_rst_seg",  {24'd0, seg},  32'hFF);
    chk("mid_rst_sel0", {26'd0, sel0}, 32'h3F);
    chk("mid_rst_seg0", {24'd0, seg0}, 32'hFF);
    data_in = 24'h001122;
    cyc(3);
    chk("hold_rst_sel", {26'd0, sel}, 32'h3F);
    chk("hold_rst_seg", {24'd0, seg}, 32'hFF);

    push_frame(24'h001122, 60);
    ecnt = 0;
    rst  = 1'b0;
    run  = 1'b1;
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    #2;
    chk("sb_drain", sb.size(), 0);
    run = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
